fifo_sync_v2: RTL
=================

# fifo_sync_v2

Parametrised synchronous FIFO for the UART path and other byte/word streaming blocks. It is the next-generation replacement for the first-generation UART FIFO. It adds:
- arbitrary (non-power-of-two) depth
- an optional first-word-fall-through read mode
- programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags

Occupancy tracks only accepted transfers.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- FIFO_DEPTH, 16, number of entries (≥2, any integer)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, FIFO_DEPTH-2, almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- w_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT)
- clr_err  in  1  synchronous clear of overflow/underflow
- r_data  out  DATA_WIDTH  read data
- rd_valid  out  1  r_data holds a newly popped word
- wr_ack  out  1  write accepted this cycle (combinational)
- empty, full  out  1  status
- almost_empty, almost_full  out  1  threshold status
- count  out  $clog2(FIFO_DEPTH+1)  occupancy
- overflow, underflow  out  1  sticky error flags

## Operation
- Acceptance:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
  - full/empty are evaluated from the current-cycle state.
- Write on full is rejected even if rd_acc is set in the same cycle, and sets overflow.
- Read on empty is rejected even if wr_en is set in the same cycle, and sets underflow.
- Count update:
  - +1 when wr_acc only
  - −1 when rd_acc only
  - unchanged when both or neither
  - Raw wr_en/rd_en never alter count.
- Pointers: w_ptr and r_ptr are index-width $clog2(FIFO_DEPTH). Each increments on its accepted transfer and wraps from FIFO_DEPTH−1 to 0 explicitly, with no reliance on power-of-two overflow.
- Status flags:
  - empty = (count==0)
  - full = (count==FIFO_DEPTH)
  - almost flags are compared against count
- Standard mode (FWFT=0):
  - r_data is registered: mem[r_ptr] is loaded on rd_acc.
  - rd_valid pulses for one cycle, on the cycle after rd_acc.
  - r_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - r_data = mem[r_ptr] (asynchronous read) whenever !empty.
  - rd_valid = !empty.
  - rd_acc pops the head.
  - r_data is don't-care while empty.
- Error flags:
  - overflow/underflow are set on a rejected request and stay high until clr_err or reset.
  - If set and clr_err occur in the same cycle, set wins.
- Memory contents are not reset.

## Timing
- Reset values:
  - r_data=0, rd_valid=0, count=0
  - empty=1, full=0
  - almost_empty=1, almost_full=0 (for AF_THRESH>0)
  - overflow=0, underflow=0
  - wr_ack follows its combinational equation.
- Reset asserted mid-operation discards all contents immediately (asynchronous). Operation resumes on the first rising edge after reset_n deasserts.
- Write → empty deasserts: 1 cycle after the wr_acc edge.
- In FWFT mode, the written word appears on r_data in that same cycle.
- Standard-mode read latency: 1 cycle from the rd_acc edge to valid r_data.
- All status outputs are registered-state derived and glitch-free relative to clk. wr_ack is the only combinational output.

## Structure
- Package fifo_pkg holds:
  - the fifo_mode_e enum (MODE_STD, MODE_FWFT), used for FWFT parameter decoding
  - the function ptr_next(ptr, depth) implementing the wrap rule
- Sub-module fifo_ram:
  - DATA_WIDTH × FIFO_DEPTH array
  - one synchronous write port
  - one read port that is either registered or asynchronous, selected by parameter
- The top module holds the control logic: pointers, count, flags, and errors.

## Test plan
- Basic fill/drain, DEPTH=5, FWFT=0:
  - Stimulus: write 0x11..0x55, then 6 reads.
  - Required: full=1 after the 5th write, count=5.
  - Required: reads return 0x11..0x55 in order, each with rd_valid 1 cycle after rd_en.
  - Required: the 6th read sets underflow, with count=0 and r_data held at 0x55.
- Wrap-around, DEPTH=5:
  - Stimulus: 13 interleaved write/read pairs with data equal to the index.
  - Required: pointers wrap past index 4 with no data loss; output sequence 0..12.
- Full with simultaneous rd+wr:
  - Stimulus: at count=5, assert wr_en=rd_en=1 with w_data=0xAA.
  - Required: read accepted, write rejected, overflow=1, count=4, wr_ack=0.
  - Required: clr_err then clears overflow.
- Empty with simultaneous rd+wr, FWFT=1:
  - Required: write accepted, underflow=1, count=1.
  - Required: next cycle empty=0 and r_data=written value.
- Thresholds, DEPTH=16, AF=14, AE=2:
  - Required: almost_empty drops at count 3; almost_full rises at count 14 and falls at 13.
- Async reset mid-stream:
  - Stimulus: assert reset_n=0 between edges at count=7.
  - Required: count=0, empty=1 and flags cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the fifo_sync_v2 slice.
//   fifo_mode_e : read-port mode decoded from the FWFT parameter
//   ptr_next()  : pointer increment with explicit wrap at depth-1, so any
//                 depth works (no reliance on power-of-two rollover)
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [0:0] {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_v2_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_v2_if
// Handshake/status bundle of fifo_sync_v2.
//   master : the client (drives wr_en, w_data, rd_en, clr_err)
//   slave  : the FIFO   (drives r_data, rd_valid, wr_ack, status, count,
//            overflow, underflow)
// ---------------------------------------------------------------------------
interface fifo_sync_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, w_data, rd_en, clr_err,
        input  r_data, rd_valid, wr_ack, empty, full, almost_empty,
               almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, w_data, rd_en, clr_err,
        output r_data, rd_valid, wr_ack, empty, full, almost_empty,
               almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DATA_WIDTH x FIFO_DEPTH storage, one synchronous write port and one read
// port that is either registered (ASYNC_RD=0, loads on re) or asynchronous
// (ASYNC_RD=1, rdata follows raddr). Array contents are never reset; only
// the registered read-data flop is.
//   clk, reset_n        : clock / async active-low reset (read flop only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port
// ---------------------------------------------------------------------------
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit ASYNC_RD   = 1'b0,
    localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = ASYNC_RD ? mem[raddr] : rdata_q;

endmodule

// File: rtl/fifo_sync_v2.sv
// ---------------------------------------------------------------------------
// fifo_sync_v2
// Synchronous FIFO with arbitrary depth, optional first-word-fall-through,
// almost-full/almost-empty thresholds, occupancy count and sticky
// overflow/underflow flags.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fifo_sync_v2_if.slave (wr_en/w_data/rd_en/clr_err in;
//              r_data/rd_valid/wr_ack/empty/full/almost_*/count/
//              overflow/underflow out)
// wr_ack is the only combinational output; everything else derives from
// registered state.
// ---------------------------------------------------------------------------
module fifo_sync_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_sync_v2_if.slave bus
);

    localparam int         PTR_W = $clog2(FIFO_DEPTH);
    localparam int         CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    logic [PTR_W-1:0] w_ptr_q;
    logic [PTR_W-1:0] r_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             empty;
    logic             full;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance looks only at the current state: a pop in the same cycle
    // never makes room for a write on full, nor a push data for a read on empty.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr_q <= PTR_W'(ptr_next(32'(w_ptr_q), FIFO_DEPTH));
            end
            if (rd_acc) begin
                r_ptr_q <= PTR_W'(ptr_next(32'(r_ptr_q), FIFO_DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            rd_valid_q  <= rd_acc;
            // Set has priority over clear.
            overflow_q  <= (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
            underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ASYNC_RD   (MODE == MODE_FWFT)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (w_ptr_q),
        .wdata   (bus.w_data),
        .re      (rd_acc),
        .raddr   (r_ptr_q),
        .rdata   (bus.r_data)
    );

    assign bus.wr_ack       = wr_acc;
    assign bus.rd_valid     = (MODE == MODE_FWFT) ? ~empty : rd_valid_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
